// File: rtl/seq_source_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_source_if
//  Brief    : Valid/ready sample bus between seq_source and its consumer.
//  Revision : 1.0
// ============================================================================
interface seq_source_if #(
    parameter int WIDTH = 10
) ();
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/seq_source.sv
`default_nettype none
// ============================================================================
//  Module   : seq_source
//  Brief    : Programmable start/step/count sample generator with valid/ready
//             backpressure. SEQ_SOURCE_SAT_EN selects a saturating adder.
//  Revision : 1.0
// ============================================================================
module seq_source #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic             abort,
    input  wire logic [WIDTH-1:0] init_val,
    input  wire logic [WIDTH-1:0] step,
    input  wire logic [CNT_W-1:0] num,
    output logic                  busy,
    output logic                  done,
    seq_source_if.master          src
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] w_step_nxt;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] w_num_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_next_sample;
    logic             w_xfer;

`ifdef SEQ_SOURCE_SAT_EN
    logic [WIDTH:0]   w_sum;
    assign w_sum         = {1'b0, r_data} + {1'b0, r_step};
    assign w_next_sample = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
    assign w_next_sample = r_data + r_step;
`endif

    assign w_xfer    = src.out_valid & src.out_ready;
    assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_step  <= '0;
            r_num   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_step  <= w_step_nxt;
            r_num   <= w_num_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_step_nxt  = r_step;
        w_num_nxt   = r_num;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_data_nxt  = init_val;
                    w_step_nxt  = step;
                    w_num_nxt   = num;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over completion; the coinciding sample is not advanced.
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_xfer) begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_data_nxt = w_next_sample;
                    if ((r_num != '0) && (w_cnt_inc == r_num)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign src.out_data  = r_data;
    assign src.out_valid = (r_state == ST_RUN);
    assign busy          = (r_state == ST_RUN);
    assign done          = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_source
//  Brief    : Self-checking bench for seq_source (arithmetic sample model plus
//             directed literal expectations).
//  Revision : 1.0
// ============================================================================
module tb_seq_source;
    localparam int W    = 10;
    localparam int MAXV = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [W-1:0]  init_val;
    logic [W-1:0]  step;
    logic [15:0]   num;
    logic          ready;
    logic          busy;
    logic          done;

    seq_source_if #(.WIDTH(W)) sif ();
    assign sif.out_ready = ready;

    seq_source #(.WIDTH(W), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .init_val (init_val),
        .step     (step),
        .num      (num),
        .busy     (busy),
        .done     (done),
        .src      (sif.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sequence mode (0 idle, 1 running, 2 done), transfers so far, captured config.
    int m_mode  = 0;
    int m_k     = 0;
    int m_init  = 0;
    int m_step  = 0;
    int m_num   = 0;
    bit m_known = 1'b0;
    bit m_en    = 1'b0;

    // Sample k of a sequence is init + k*step, wrapped or clamped.
    function automatic logic [W-1:0] f(input int k);
        longint v;
        logic [63:0] r;
        v = longint'(m_init) + longint'(k) * longint'(m_step);
`ifdef SEQ_SOURCE_SAT_EN
        if (v > MAXV) v = MAXV;
`else
        v = v % (longint'(1) << W);
`endif
        r = 64'(v);
        return r[W-1:0];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_k = 0; m_init = 0; m_step = 0; m_num = 0;
            m_known = 1'b1; m_en = 1'b1;
        end else begin
            case (m_mode)
                0: if (start && !abort) begin
                    m_init = int'(init_val); m_step = int'(step); m_num = int'(num);
                    m_k = 0; m_mode = 1; m_known = 1'b1;
                end
                1: if (abort) begin
                    m_mode = 0; m_known = 1'b0;
                end else if (ready) begin
                    m_k++;
                    if (m_num != 0 && m_k == m_num) m_mode = 2;
                end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            chk("out_valid", 32'(sif.out_valid), 32'(m_mode == 1));
            chk("busy",      32'(busy),          32'(m_mode == 1));
            chk("done",      32'(done),          32'(m_mode == 2));
            if (m_known) chk("out_data", 32'(sif.out_data), 32'(f(m_k)));
            if (sif.out_valid && ready) q.push_back(int'(sif.out_data));
            if (done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int iv, input int st, input int n);
        q.delete();
        init_val = W'(iv);
        step     = W'(st);
        num      = 16'(n);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = n_done;
        for (int i = 0; i < budget && n_done == d0; i++) tick();
        chk({name, "_timeout"}, 32'(n_done != d0), 32'd1);
    endtask

    int d_before;
    int stall_tbl[5] = '{1, 0, 0, 1, 1};

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
        init_val = '0; step = '0; num = '0;
        repeat (3) tick();
        chk("rst_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_data",  32'(sif.out_data),  32'd0);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_done",  32'(done),          32'd0);
        rst_n = 1'b1;
        tick();

        // Basic count-up 1..19
        ready = 1'b1;
        d_before = n_done;
        launch(1, 1, 19);
        chk("t1_valid_latency", 32'(sif.out_valid), 32'd1);
        wait_done("t1", 40);
        chk("t1_count", 32'(q.size()), 32'd19);
        chk("t1_first", 32'(q[0]),     32'd1);
        chk("t1_last",  32'(q[18]),    32'd19);
        tick();
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_one_done", 32'(n_done - d_before), 32'd1);

        // Wrap (or saturate) at the top of the range
        launch(1020, 3, 4);
        wait_done("t2", 20);
        chk("t2_count", 32'(q.size()), 32'd4);
        chk("t2_s0", 32'(q[0]), 32'd1020);
        chk("t2_s1", 32'(q[1]), 32'd1023);
`ifdef SEQ_SOURCE_SAT_EN
        chk("t2_s2", 32'(q[2]), 32'd1023);
        chk("t2_s3", 32'(q[3]), 32'd1023);
`else
        chk("t2_s2", 32'(q[2]), 32'd2);
        chk("t2_s3", 32'(q[3]), 32'd5);
`endif
        tick();

        // Backpressure with stalls; start during DONE is ignored
        d_before = n_done;
        launch(5, 2, 3);
        for (int i = 0; i < 5; i++) begin
            ready = stall_tbl[i][0];
            if (i == 2) chk("t3_hold", 32'(sif.out_data), 32'd7);
            tick();
        end
        chk("t3_done_pulse", 32'(done), 32'd1);
        init_val = W'(200); start = 1'b1;
        tick();
        start = 1'b0; ready = 1'b1;
        chk("t3_start_in_done_ignored", 32'(busy), 32'd0);
        chk("t3_count", 32'(q.size()), 32'd3);
        chk("t3_s0", 32'(q[0]), 32'd5);
        chk("t3_s1", 32'(q[1]), 32'd7);
        chk("t3_s2", 32'(q[2]), 32'd9);
        chk("t3_one_done", 32'(n_done - d_before), 32'd1);
        tick();

        // Endless stream aborted after 10 transfers, then immediate restart
        d_before = n_done;
        launch(0, 1, 0);
        repeat (10) tick();
        ready = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0; ready = 1'b1;
        chk("t4_valid_after_abort", 32'(sif.out_valid), 32'd0);
        chk("t4_count", 32'(q.size()), 32'd10);
        chk("t4_last", 32'(q[9]), 32'd9);
        chk("t4_no_done", 32'(n_done - d_before), 32'd0);
        launch(3, 0, 2);
        chk("t4_restart_busy", 32'(busy), 32'd1);
        wait_done("t4b", 10);
        chk("t4b_s0", 32'(q[0]), 32'd3);
        chk("t4b_s1", 32'(q[1]), 32'd3);
        tick();

        // Reset mid-sequence
        d_before = n_done;
        launch(0, 1, 8);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        chk("t5_valid", 32'(sif.out_valid), 32'd0);
        chk("t5_data",  32'(sif.out_data),  32'd0);
        chk("t5_busy",  32'(busy),          32'd0);
        rst_n = 1'b1;
        repeat (6) tick();
        chk("t5_no_done", 32'(n_done - d_before), 32'd0);

        // Re-start while busy is ignored
        launch(10, 2, 5);
        tick();
        init_val = W'(100); start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t6", 20);
        chk("t6_count", 32'(q.size()), 32'd5);
        chk("t6_s0", 32'(q[0]), 32'd10);
        chk("t6_s4", 32'(q[4]), 32'd18);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seq_source.md
Name: seq_source

Overview:
- Programmable sequence generator that produces the WIDTH-bit sample stream consumed by the 10-bit register stage.
- Replaces free-running "x = x + 1" stimulus with a synthesizable, handshaked source:
  - configurable start value, step and sample count;
  - valid/ready backpressure.
- Sits directly upstream of the register stage; out_data drives that stage's input bus.

Parameters:
WIDTH, 10, sample width in bits
CNT_W, 16, width of the sample-count field and internal sample counter

Ports:
clk        input   1        single clock, all state updates on rising edge
rst_n      input   1        synchronous active-low reset
start      input   1        one-cycle pulse; launches a sequence when idle
abort      input   1        terminates the current sequence
init_val   input   WIDTH    first sample value, captured on accepted start
step       input   WIDTH    increment between samples, captured on accepted start
num        input   CNT_W    samples to emit; 0 = endless until abort
out_data   output  WIDTH    current sample
out_valid  output  1        out_data holds a valid sample
out_ready  input   1        downstream accepts the sample this cycle
busy       output  1        high in RUN state
done       output  1        one-cycle pulse after the last sample is accepted

Behaviour:
- Reset: rst_n low at a rising edge forces state=IDLE, out_data=0, out_valid=0, busy=0, done=0, sample counter=0, captured step=0, captured num=0. Applies mid-sequence; no partial completion, no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 (and abort=0) -> capture init_val into out_data, capture step and num, clear counter, go RUN.
  - out_valid and busy rise in the cycle after start (latency 1).
- RUN:
  - out_valid=1, busy=1.
  - Transfer = out_valid & out_ready in the same cycle.
  - On transfer: counter += 1; out_data <= out_data + step, truncated to WIDTH bits (wraps modulo 2^WIDTH).
  - If num!=0 and the transfer is the num-th one: go DONE. out_valid drops next cycle; out_data keeps its last computed value.
  - No transfer (out_ready=0): out_data, out_valid and the counter hold exactly stable.
- DONE:
  - done=1 for exactly one cycle, out_valid=0, busy=0.
  - Unconditionally returns to IDLE; start in this cycle is ignored.
- abort: in RUN or DONE, goes IDLE at the next edge with out_valid=0, busy=0, done=0.
  - A transfer coinciding with abort still counts for downstream, but no further samples are produced.
  - abort has priority over start and over completion.
- start while busy or in DONE: ignored; captured configuration is unchanged.
- num=0: endless stream; counter wraps silently at 2^CNT_W and never triggers DONE.
- num=1: single sample (init_val), then DONE.
- step=0: constant stream of init_val.
- Inputs init_val/step/num are sampled only on an accepted start; later changes have no effect on a running sequence.

Optional Feature:
Macro SEQ_SOURCE_SAT_EN.
- Defined: the next-sample adder saturates at 2^WIDTH-1 instead of wrapping. Once saturated, out_data stays at all-ones for the remaining samples; count and done behaviour are unchanged.
- Undefined: modulo-2^WIDTH wrap as described under Behaviour.

Test Plan:
- Reset, then start with init_val=1, step=1, num=19, out_ready=1 -> out_valid rises one cycle after start; samples 1..19 on consecutive cycles; done pulses one cycle after sample 19; busy low afterwards.
- init_val=1020, step=3, num=4, out_ready=1 -> samples 1020, 1023, 2, 5 with wrap. With SEQ_SOURCE_SAT_EN defined -> 1020, 1023, 1023, 1023.
- init_val=5, step=2, num=3, out_ready toggling 1,0,0,1,1 -> samples 5, 7, 9; out_data holds 7 through both stall cycles; exactly 3 transfers, then one done pulse.
- num=0, init_val=0, step=1, abort asserted after 10 transfers -> samples 0..9 then out_valid=0, no done pulse; state IDLE; a new start is accepted the following cycle.
- rst_n=0 asserted mid-sequence after sample 4 of num=8 -> next edge out_valid=0, out_data=0, busy=0, done never pulses.
- start pulsed again while busy with different init_val=100 -> ignored; original sequence completes with unchanged values and count.
